// File: rtl/br_predictor_if.sv
// ---------------------------------------------------------------------------
// br_predictor_if
// Bundles the fetch-side lookup, the branch-unit training port and the ROB
// flush-recovery port of the branch direction predictor.
//
// Parameter:
//   SIZE_GLOBAL   global history width (also the PHT index width)
//
// Signals:
//   fetch_req, fetch_pc          lookup request from fetch
//   pred_taken, pred_history     combinational prediction + history snapshot
//   br_finish, br_op, br_en,
//   br_pc, br_history_old        resolved-branch training update
//   flush, flush_is_br,
//   flush_taken, flush_history   speculative history repair on ROB redirect
//
// Modports:
//   master  the pipeline side (drives requests, receives predictions)
//   slave   the predictor
// ---------------------------------------------------------------------------
interface br_predictor_if #(
  parameter int SIZE_GLOBAL = 8
);
  logic                   fetch_req;
  logic [31:0]            fetch_pc;
  logic                   pred_taken;
  logic [SIZE_GLOBAL-1:0] pred_history;

  logic                   br_finish;
  logic                   br_op;
  logic                   br_en;
  logic [31:0]            br_pc;
  logic [SIZE_GLOBAL-1:0] br_history_old;

  logic                   flush;
  logic                   flush_is_br;
  logic                   flush_taken;
  logic [SIZE_GLOBAL-1:0] flush_history;

  modport master (
    output fetch_req, fetch_pc,
    output br_finish, br_op, br_en, br_pc, br_history_old,
    output flush, flush_is_br, flush_taken, flush_history,
    input  pred_taken, pred_history
  );

  modport slave (
    input  fetch_req, fetch_pc,
    input  br_finish, br_op, br_en, br_pc, br_history_old,
    input  flush, flush_is_br, flush_taken, flush_history,
    output pred_taken, pred_history
  );
endinterface

// File: rtl/br_predictor.sv
// ---------------------------------------------------------------------------
// br_predictor
// Global-history conditional-branch direction predictor. A table of
// 2^SIZE_GLOBAL two-bit saturating counters (PHT) is indexed by the branch
// PC word bits, optionally hashed with the global history register (GHR).
// The GHR is shifted speculatively with each prediction, repaired on ROB
// flush, and the PHT is trained with resolved outcomes.
//
// Build option:
//   BR_PRED_GSHARE_EN  defined   -> index = pc[SIZE_GLOBAL+1:2] ^ history
//                      undefined -> index = pc[SIZE_GLOBAL+1:2] (bimodal);
//                      the GHR and its recovery still run so the
//                      downstream history snapshot is unchanged.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (GHR = 0, all counters = 01)
//   bus   br_predictor_if.slave: lookup, training and flush ports
// ---------------------------------------------------------------------------
module br_predictor #(
  parameter int SIZE_GLOBAL = 8
) (
  input logic           clk,
  input logic           rst,
  br_predictor_if.slave bus
);

  localparam int PHT_N = 1 << SIZE_GLOBAL;

  typedef logic [SIZE_GLOBAL-1:0] hist_t;

  // The history mask folds the build option into one place: with all ones
  // the history hashes into the index, with all zeros it drops out.
`ifdef BR_PRED_GSHARE_EN
  localparam hist_t HIST_MASK = '1;
`else
  localparam hist_t HIST_MASK = '0;
`endif

  hist_t      ghr;
  hist_t      ghr_next;
  logic [1:0] pht [PHT_N];

  hist_t      lookup_idx;
  hist_t      train_idx;
  logic       pred_bit;
  logic       train_en;
  logic [1:0] train_next;

  // Only the word-index bits of the PCs address the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.fetch_pc[31:SIZE_GLOBAL+2], bus.fetch_pc[1:0],
                            bus.br_pc[31:SIZE_GLOBAL+2], bus.br_pc[1:0]};

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic hist_t pht_index(input hist_t pc_word, input hist_t h);
    return pc_word ^ (h & HIST_MASK);
  endfunction

  // Lookup is purely combinational; a same-cycle training write to the same
  // entry is not bypassed, so the lookup sees the pre-update counter.
  assign lookup_idx       = pht_index(bus.fetch_pc[SIZE_GLOBAL+1:2], ghr);
  assign pred_bit         = pht[lookup_idx][1];
  assign bus.pred_taken   = pred_bit;
  assign bus.pred_history = ghr;

  assign train_en   = bus.br_finish && bus.br_op;
  assign train_idx  = pht_index(bus.br_pc[SIZE_GLOBAL+1:2], bus.br_history_old);
  assign train_next = bus.br_en ? sat_inc(pht[train_idx]) : sat_dec(pht[train_idx]);

  // Flush repair wins over the speculative shift. A flushing conditional
  // branch re-inserts its own resolved outcome on top of its snapshot.
  always_comb begin
    ghr_next = ghr;
    if (bus.flush) begin
      if (bus.flush_is_br) begin
        ghr_next = {bus.flush_history[SIZE_GLOBAL-2:0], bus.flush_taken};
      end else begin
        ghr_next = bus.flush_history;
      end
    end else if (bus.fetch_req) begin
      ghr_next = {ghr[SIZE_GLOBAL-2:0], pred_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else begin
      ghr <= ghr_next;
    end
  end

  // Every counter restarts at weakly not-taken; a training update in the
  // reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (train_en) begin
      pht[train_idx] <= train_next;
    end
  end

endmodule

// File: tb/tb_br_predictor.sv
// ---------------------------------------------------------------------------
// tb_br_predictor
// Directed and randomized bench for br_predictor (SIZE_GLOBAL = 8). A
// behavioural model (integer counter table plus history value) tracks the
// expected prediction and history each cycle; directed steps additionally
// compare against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_br_predictor;

  localparam int SG = 8;

`ifdef BR_PRED_GSHARE_EN
  localparam int HMASK = 32'hFF;
`else
  localparam int HMASK = 32'h00;
`endif

  logic clk = 1'b0;
  logic rst;

  br_predictor_if #(.SIZE_GLOBAL(SG)) bus ();

  br_predictor #(.SIZE_GLOBAL(SG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int       pht_m [256];
  int       ghr_m;

  function automatic int midx(input logic [31:0] pc, input int h);
    return int'((pc >> 2) & 32'hFF) ^ (h & HMASK);
  endfunction

  task automatic model_reset();
    ghr_m = 0;
    for (int i = 0; i < 256; i++) pht_m[i] = 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven: checks the
  // combinational outputs against the model, advances the model by the rules
  // of one rising edge, and returns after the next falling edge.
  task automatic tick();
    int exp_taken;
    int e;
    #1;
    exp_taken = (pht_m[midx(bus.fetch_pc, ghr_m)] >= 2) ? 1 : 0;
    check("model_pred_taken", 32'(bus.pred_taken), 32'(exp_taken));
    check("model_pred_history", 32'(bus.pred_history), 32'(ghr_m));
    if (rst) begin
      model_reset();
    end else begin
      if (bus.br_finish && bus.br_op) begin
        e = midx(bus.br_pc, int'(bus.br_history_old));
        if (bus.br_en) pht_m[e] = (pht_m[e] + 1 > 3) ? 3 : pht_m[e] + 1;
        else           pht_m[e] = (pht_m[e] - 1 < 0) ? 0 : pht_m[e] - 1;
      end
      if (bus.flush) begin
        if (bus.flush_is_br) ghr_m = ((int'(bus.flush_history) * 2) + int'(bus.flush_taken)) % 256;
        else                 ghr_m = int'(bus.flush_history);
      end else if (bus.fetch_req) begin
        ghr_m = (ghr_m * 2 + exp_taken) % 256;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_req = 1'b0;      bus.fetch_pc = '0;
    bus.br_finish = 1'b0;      bus.br_op = 1'b0;  bus.br_en = 1'b0;
    bus.br_pc = '0;            bus.br_history_old = '0;
    bus.flush = 1'b0;          bus.flush_is_br = 1'b0;
    bus.flush_taken = 1'b0;    bus.flush_history = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset state
    bus.fetch_pc = 32'h40; #1;
    check("rst_pred", 32'(bus.pred_taken), 0);
    check("rst_hist", 32'(bus.pred_history), 0);
    tick();
    bus.fetch_pc = 32'h1234; #1;
    check("rst_pred2", 32'(bus.pred_taken), 0);
    tick();

    // Saturation on entry 0x10
    bus.fetch_pc = 32'h40;
    bus.br_finish = 1'b1; bus.br_op = 1'b1; bus.br_en = 1'b1;
    bus.br_pc = 32'h40;   bus.br_history_old = '0;
    repeat (4) tick();
    bus.br_finish = 1'b0; #1;
    check("sat_hi", 32'(bus.pred_taken), 1);
    tick();
    bus.br_finish = 1'b1; bus.br_en = 1'b0;
    tick();
    #1;
    check("sat_one_dec", 32'(bus.pred_taken), 1);
    tick();
    tick();
    bus.br_finish = 1'b0; #1;
    check("sat_lo", 32'(bus.pred_taken), 0);
    tick();
    bus.br_finish = 1'b1; bus.br_en = 1'b1;
    tick();
    bus.br_finish = 1'b0; #1;
    check("sat_floor", 32'(bus.pred_taken), 0);
    tick();

    // Speculative shift: make entry 0x20 strongly taken, then predict 1, 0
    bus.fetch_pc = 32'h0;
    bus.br_finish = 1'b1; bus.br_en = 1'b1; bus.br_pc = 32'h80; bus.br_history_old = '0;
    repeat (2) tick();
    bus.br_finish = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h80; #1;
    check("spec_p1", 32'(bus.pred_taken), 1);
    tick();
    bus.fetch_pc = 32'hC0; #1;
    check("spec_p2", 32'(bus.pred_taken), 0);
    check("spec_h2", 32'(bus.pred_history), 32'h01);
    tick();
    bus.fetch_pc = 32'h100; #1;
    check("spec_h3", 32'(bus.pred_history), 32'h02);
    tick();

    // Flush overrides the fetch shift
    bus.flush = 1'b1; bus.flush_is_br = 1'b1; bus.flush_taken = 1'b1;
    bus.flush_history = 8'h05;
    tick();
    bus.flush = 1'b0; bus.fetch_req = 1'b0; #1;
    check("flush_prio", 32'(bus.pred_history), 32'h0B);
    tick();

    // Non-branch flush restores the snapshot verbatim
    bus.flush = 1'b1; bus.flush_is_br = 1'b0; bus.flush_history = 8'h3C;
    tick();
    bus.flush = 1'b0; #1;
    check("flush_nonbr", 32'(bus.pred_history), 32'h3C);

    // jal/jalr completions must leave the table alone
    bus.br_finish = 1'b1; bus.br_op = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.br_pc = 32'h40 + 32'(i * 64);
      bus.br_en = i[0];
      bus.br_history_old = 8'h3C;
      tick();
    end
    bus.br_finish = 1'b0; bus.br_op = 1'b1;

    // Sweep every entry with GHR = 0x3C: only the entry trained to 11 reads taken
    for (int i = 0; i < 256; i++) begin
      bus.fetch_pc = 32'(i) << 2; #1;
      check("sweep", 32'(bus.pred_taken), ((i ^ (32'h3C & HMASK)) == 32'h20) ? 1 : 0);
      tick();
    end

    // Same-entry lookup and training in one cycle
    bus.flush = 1'b1; bus.flush_is_br = 1'b0; bus.flush_history = 8'h00;
    tick();
    bus.flush = 1'b0;
    bus.fetch_pc = 32'h40;
    bus.br_finish = 1'b1; bus.br_op = 1'b1; bus.br_en = 1'b1;
    bus.br_pc = 32'h40; bus.br_history_old = '0; #1;
    check("coll_old", 32'(bus.pred_taken), 0);
    tick();
    bus.br_finish = 1'b0; #1;
    check("coll_new", 32'(bus.pred_taken), 1);
    tick();

    // History excluded from the index only in the bimodal build
    bus.flush = 1'b1; bus.flush_is_br = 1'b0; bus.flush_history = 8'h5A;
    tick();
    bus.flush = 1'b0; bus.fetch_pc = 32'h40; #1;
    check("hist_in_index", 32'(bus.pred_taken), (HMASK == 0) ? 1 : 0);
    tick();

    // Mid-operation reset drops the same-cycle updates
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h80;
    bus.br_finish = 1'b1; bus.br_op = 1'b1; bus.br_en = 1'b1;
    bus.br_pc = 32'h80; bus.br_history_old = '0;
    bus.flush = 1'b1; bus.flush_is_br = 1'b0; bus.flush_history = 8'hFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.fetch_req = 1'b0; bus.br_finish = 1'b0; bus.flush = 1'b0; #1;
    check("mid_rst_pred", 32'(bus.pred_taken), 0);
    check("mid_rst_hist", 32'(bus.pred_history), 0);
    tick();

    // Randomized traffic over a small PC pool so entries collide often
    for (int n = 0; n < 3000; n++) begin
      rst               = ($urandom_range(0, 999) == 0);
      bus.fetch_req     = $urandom_range(0, 1);
      bus.fetch_pc      = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                          | 32'($urandom_range(0, 3));
      bus.br_finish     = ($urandom_range(0, 3) != 0);
      bus.br_op         = ($urandom_range(0, 4) != 0);
      bus.br_en         = $urandom_range(0, 1);
      bus.br_pc         = 32'h1000 | (32'($urandom_range(0, 15)) << 2);
      bus.br_history_old = ($urandom_range(0, 1) == 0) ? 8'(ghr_m) : 8'($urandom_range(0, 3));
      bus.flush         = ($urandom_range(0, 15) == 0);
      bus.flush_is_br   = $urandom_range(0, 1);
      bus.flush_taken   = $urandom_range(0, 1);
      bus.flush_history = 8'($urandom_range(0, 255));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/br_predictor.md
# br_predictor

Global-history (gshare) conditional-branch direction predictor. The fetch stage queries it with the PC of each conditional branch. It returns a taken/not-taken prediction and the global history snapshot the branch must carry down to the branch reservation station (`rs2_br_history`). It trains on resolved outcomes from the branch unit (`br_finish`, `br_op`, `br_en`, `br_pc`, `br_history_old`) and repairs its speculative history when the ROB flushes.

## Interface
Parameters:
- `SIZE_GLOBAL`, 8: global history width. Also the PHT index width, so the PHT has 2^SIZE_GLOBAL entries of 2 bits.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  fetch holds a conditional branch at `fetch_pc` this cycle.
- `fetch_pc`  in  32  PC of the branch being predicted.
- `pred_taken`  out  1  predicted direction (combinational).
- `pred_history`  out  SIZE_GLOBAL  GHR value before this branch's speculative shift (combinational). Travels with the instruction.
- `br_finish`  in  1  branch unit resolved an instruction this cycle.
- `br_op`  in  1  1 = conditional branch; 0 = jal/jalr (no training).
- `br_en`  in  1  actual outcome (1 = taken).
- `br_pc`  in  32  PC of the resolved branch.
- `br_history_old`  in  SIZE_GLOBAL  history snapshot carried by the resolved branch.
- `flush`  in  1  ROB redirect this cycle.
- `flush_is_br`  in  1  flushing instruction is a conditional branch.
- `flush_taken`  in  1  actual outcome of the flushing branch.
- `flush_history`  in  SIZE_GLOBAL  history snapshot of the flushing instruction.

## Operation
- State:
  - GHR: SIZE_GLOBAL bits.
  - PHT: 2^SIZE_GLOBAL 2-bit saturating counters. 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.
- Index function: `idx(pc, h) = pc[SIZE_GLOBAL+1:2] ^ h`.
- Lookup:
  - `pred_taken = PHT[idx(fetch_pc, GHR)][1]`.
  - `pred_history = GHR`.
  - Both are valid regardless of `fetch_req`.
- Speculative history: when `fetch_req` is high and `flush` is low, the GHR becomes `{GHR[SIZE_GLOBAL-2:0], pred_taken}`.
- Training: when `br_finish && br_op`, the entry `e = idx(br_pc, br_history_old)` is updated.
  - If `br_en` is high, increment `e`, saturating at 11.
  - If `br_en` is low, decrement `e`, saturating at 00.
  - jal/jalr (`br_op` = 0) never touch the PHT.
- Recovery on `flush`:
  - If `flush_is_br` is high, the GHR becomes `{flush_history[SIZE_GLOBAL-2:0], flush_taken}`.
  - Otherwise the GHR becomes `flush_history`.
- Simultaneous events:
  - `flush` overrides `fetch_req` for the GHR; that cycle's fetch shift is discarded.
  - Training proceeds in a cycle where `flush` is high; PHT and GHR updates are independent.
  - If a lookup and a training write hit the same entry in the same cycle, the lookup returns the pre-update value. There is no bypass.
- Reset: GHR = 0. Every PHT entry = 01. With GHR = 0 and all entries 01, `pred_taken` = 0 and `pred_history` = 0 in the first cycle after reset.

## Timing
- Lookup latency is 0 cycles: `pred_taken` and `pred_history` are combinational from `fetch_pc` and the GHR.
- GHR shift, GHR recovery and PHT training take effect at the next rising edge and are visible one cycle later.
- There is no handshake and no back-pressure.
- The block accepts one lookup and one training update per cycle.
- If `rst` is asserted mid-operation, all state is reinitialised at that edge and any pending update in the same cycle is dropped.
- History wrap: the MSB shifts out and is discarded.

## Configuration
- `BR_PRED_GSHARE_EN` defined: index = `pc[SIZE_GLOBAL+1:2] ^ history` (gshare), as described above.
- `BR_PRED_GSHARE_EN` undefined: index = `pc[SIZE_GLOBAL+1:2]` (bimodal).
  - The GHR, `pred_history` and the flush recovery still operate identically, so the downstream interface is unchanged.
  - The history value is simply excluded from the index.

## Test plan
- Reset behaviour: assert `rst` 1 cycle, then `fetch_pc` = 0x40 -> `pred_taken` = 0, `pred_history` = 0. A second lookup at any PC also gives 0.
- Saturation (SIZE_GLOBAL = 8, gshare): three `br_finish`/`br_op` = 1/`br_en` = 1 at `br_pc` = 0x40, `br_history_old` = 0 -> entry 0x10 = 11. A fourth update stays at 11. Lookup 0x40 with GHR = 0 -> `pred_taken` = 1. Three not-taken updates bring it to 00.
- Speculative shift: after two `fetch_req` pulses whose predictions are 1 then 0 -> GHR = 0b10. On the third request, `pred_history` = 0x02.
- Flush priority: in the same cycle drive `fetch_req` = 1, `flush` = 1, `flush_is_br` = 1, `flush_taken` = 1, `flush_history` = 0x05 -> next-cycle GHR = 0x0B.
- Non-branch flush: `flush_is_br` = 0, `flush_history` = 0x3C -> GHR = 0x3C. A jal (`br_op` = 0) with `br_finish` = 1 leaves all PHT entries unchanged.
- Same-entry read/write collision: update and lookup the same entry in one cycle -> lookup returns the old counter bit and the new value appears next cycle. Repeat with `BR_PRED_GSHARE_EN` undefined: index ignores the GHR, so PC 0x40 maps to entry 0x10 for any history.
